// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a classic 5-stage in-order pipeline.
// Tracks the destination of the instructions in EX, MEM and WB, raises a
// combinational stall on read-after-write hazards that forwarding cannot
// cover, raises flush on a taken redirect, and produces registered operand
// forwarding selects for the instruction entering EX.
module pipe_hazard_ctrl #(
    parameter int RA_W     = 4,
    parameter int FWD_EN   = 1,
    parameter int ZERO_REG = 0,
    parameter int CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_wr_en,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Operand select encodings seen by the EX-stage operand muxes.
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    // Shadow slot indices.
    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    typedef struct packed {
        logic            valid;
        logic            wr_en;
        logic [RA_W-1:0] rd;
        logic            is_load;
    } slot_t;

    slot_t [2:0]      slot_q;
    slot_t [2:0]      slot_d;
    logic [1:0]       fwd_a_q;
    logic [1:0]       fwd_a_d;
    logic [1:0]       fwd_b_q;
    logic [1:0]       fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    logic             need_rs1;
    logic             need_rs2;
    logic [1:0]       hit_rs1;
    logic [1:0]       hit_rs2;
    logic             raw_hazard;
    logic             enter_valid;

    // A source only matters when the ID instruction is real and actually
    // reads it; a hard-wired zero register never carries a dependency.
    assign need_rs1 = id_valid & id_rs1_used & ~((ZERO_REG != 0) && (id_rs1 == '0));
    assign need_rs2 = id_valid & id_rs2_used & ~((ZERO_REG != 0) && (id_rs2 == '0));

    // Per-slot producer match for the EX and MEM slots. The WB slot is never
    // consulted: the register file writes before it is read.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_hit
            assign hit_rs1[gi] = slot_q[gi].valid & slot_q[gi].wr_en &
                                 (slot_q[gi].rd == id_rs1) & need_rs1;
            assign hit_rs2[gi] = slot_q[gi].valid & slot_q[gi].wr_en &
                                 (slot_q[gi].rd == id_rs2) & need_rs2;
        end
    endgenerate

    // With forwarding only a load in EX cannot supply its result in time;
    // without forwarding any in-flight producer ahead of WB must drain.
    generate
        if (FWD_EN != 0) begin : g_raw_fwd
            assign raw_hazard = slot_q[EX].is_load & (hit_rs1[EX] | hit_rs2[EX]);
        end else begin : g_raw_nofwd
            assign raw_hazard = (|hit_rs1) | (|hit_rs2);
        end
    endgenerate

    // Redirect beats stall; both are held low while reset is asserted.
    assign flush = Rst & ex_redirect;
    assign stall = Rst & raw_hazard & ~ex_redirect;

    // The ID instruction moves into EX only when it is neither held nor squashed.
    assign enter_valid = id_valid & ~stall & ~flush;

    // Shadow slot advance: the ID fields enter EX, older slots shift down.
    always_comb begin
        slot_d              = slot_q;
        slot_d[WB]          = slot_q[MEM];
        slot_d[MEM]         = slot_q[EX];
        slot_d[EX].valid    = enter_valid;
        slot_d[EX].wr_en    = id_wr_en;
        slot_d[EX].rd       = id_rd;
        slot_d[EX].is_load  = id_is_load;
    end

    // Forwarding select for the instruction entering EX; the EX-slot
    // producer is younger than the MEM-slot one, so it is checked first.
    always_comb begin
        fwd_a_d = SEL_RF;
        fwd_b_d = SEL_RF;
        if ((FWD_EN != 0) && enter_valid) begin
            if (hit_rs1[EX]) begin
                fwd_a_d = SEL_MEM;
            end else if (hit_rs1[MEM]) begin
                fwd_a_d = SEL_WB;
            end
            if (hit_rs2[EX]) begin
                fwd_b_d = SEL_MEM;
            end else if (hit_rs2[MEM]) begin
                fwd_b_d = SEL_WB;
            end
        end
    end

    // Saturating event counters for stall and flush cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            slot_q      <= '0;
            fwd_a_q     <= SEL_RF;
            fwd_b_q     <= SEL_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            slot_q      <= slot_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_a     = fwd_a_q;
    assign fwd_b     = fwd_b_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // The WB slot and the non-EX load flags are tracked for pipeline
    // visibility but nothing downstream needs them.
    logic slot_unused;
    assign slot_unused = ^{slot_q[WB], slot_q[MEM].is_load, slot_q[EX].is_load};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Three configurations share one
// stimulus stream: u0 forwarding, u1 stall-only with 2-bit counters,
// u2 forwarding with hard-wired r0. A reference model tracks the last three
// issued instructions by age and derives every expected output from the
// hazard rules directly.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [3:0] id_rs1;
    logic [3:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic       id_wr_en;
    logic [3:0] id_rd;
    logic       id_is_load;
    logic       ex_redirect;

    logic        st0, st1, st2;
    logic        fl0, fl1, fl2;
    logic [1:0]  fa0, fa1, fa2;
    logic [1:0]  fb0, fb1, fb2;
    logic [15:0] sc0, fc0, sc2, fc2;
    logic [1:0]  sc1, fc1;

    int total = 0;
    int bad   = 0;
    int step_no = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RA_W(4), .FWD_EN(1), .ZERO_REG(0), .CNT_W(16)) u0 (
        .Clk(clk), .Rst(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_wr_en(id_wr_en),
        .id_rd(id_rd), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .stall(st0), .flush(fl0), .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(sc0), .flush_cnt(fc0));

    pipe_hazard_ctrl #(.RA_W(4), .FWD_EN(0), .ZERO_REG(0), .CNT_W(2)) u1 (
        .Clk(clk), .Rst(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_wr_en(id_wr_en),
        .id_rd(id_rd), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .stall(st1), .flush(fl1), .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(sc1), .flush_cnt(fc1));

    pipe_hazard_ctrl #(.RA_W(4), .FWD_EN(1), .ZERO_REG(1), .CNT_W(16)) u2 (
        .Clk(clk), .Rst(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_wr_en(id_wr_en),
        .id_rd(id_rd), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .stall(st2), .flush(fl2), .fwd_a(fa2), .fwd_b(fb2), .stall_cnt(sc2), .flush_cnt(fc2));

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        bit we;
        bit ld;
        int rd;
    } ins_t;

    int   p_fwd [3] = '{1, 0, 1};
    int   p_zr  [3] = '{0, 0, 1};
    int   p_cw  [3] = '{16, 2, 16};
    ins_t hist  [3][3];          // [instance][age]: age 0 = one cycle ago (EX)
    int   e_fa  [3];
    int   e_fb  [3];
    int   e_sc  [3];
    int   e_fc  [3];

    function automatic bit m_writes(int i, int age, int r);
        ins_t e = hist[i][age];
        return e.v && e.we && (e.rd == r) && !(p_zr[i] == 1 && r == 0);
    endfunction

    function automatic bit m_raw(int i);
        bit n1 = id_valid && id_rs1_used;
        bit n2 = id_valid && id_rs2_used;
        int r1 = int'(id_rs1);
        int r2 = int'(id_rs2);
        for (int age = 0; age < 2; age++) begin
            if (p_fwd[i] == 1 && (age > 0 || !hist[i][age].ld)) continue;
            if ((n1 && m_writes(i, age, r1)) || (n2 && m_writes(i, age, r2))) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_stall(int i);
        return rst_n && m_raw(i) && !ex_redirect;
    endfunction

    function automatic bit m_flush();
        return rst_n && ex_redirect;
    endfunction

    // Distance to the youngest producer: 1 -> MEM result, 2 -> WB result.
    function automatic int m_src(int i, bit needed, int r);
        if (p_fwd[i] == 0 || !needed) return 0;
        for (int age = 0; age < 2; age++) begin
            if (m_writes(i, age, r)) return age + 1;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int a = 0; a < 3; a++) hist[i][a] = '{0, 0, 0, 0};
            e_fa[i] = 0; e_fb[i] = 0; e_sc[i] = 0; e_fc[i] = 0;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_inst(input int i, input logic s, input logic f, input logic [1:0] a,
                            input logic [1:0] b, input logic [31:0] sc, input logic [31:0] fc);
        chk($sformatf("s%0d.u%0d.stall", step_no, i), {31'b0, s}, {31'b0, m_stall(i)});
        chk($sformatf("s%0d.u%0d.flush", step_no, i), {31'b0, f}, {31'b0, m_flush()});
        chk($sformatf("s%0d.u%0d.fwd_a", step_no, i), {30'b0, a}, e_fa[i]);
        chk($sformatf("s%0d.u%0d.fwd_b", step_no, i), {30'b0, b}, e_fb[i]);
        chk($sformatf("s%0d.u%0d.stall_cnt", step_no, i), sc, e_sc[i]);
        chk($sformatf("s%0d.u%0d.flush_cnt", step_no, i), fc, e_fc[i]);
    endtask

    // Apply one ID-stage transaction, then compare all outputs at the falling edge.
    task automatic drive(input bit rst, input bit v, input int r1, input bit u1_, input int r2,
                         input bit u2_, input bit we, input int rd, input bit ld, input bit redir);
        rst_n = rst; id_valid = v; id_rs1 = 4'(r1); id_rs1_used = u1_; id_rs2 = 4'(r2);
        id_rs2_used = u2_; id_wr_en = we; id_rd = 4'(rd); id_is_load = ld; ex_redirect = redir;
        step_no++;
        @(negedge clk);
        $display("step %0d rst=%0b v=%0b rs1=%0d/%0b rs2=%0d/%0b we=%0b rd=%0d ld=%0b redir=%0b stall=%0b%0b%0b flush=%0b",
                 step_no, rst, v, r1, u1_, r2, u2_, we, rd, ld, redir, st0, st1, st2, fl0);
        chk_inst(0, st0, fl0, fa0, fb0, {16'b0, sc0}, {16'b0, fc0});
        chk_inst(1, st1, fl1, fa1, fb1, {30'b0, sc1}, {30'b0, fc1});
        chk_inst(2, st2, fl2, fa2, fb2, {16'b0, sc2}, {16'b0, fc2});
    endtask

    // Advance the model by one clock edge, then move to just after that edge.
    task automatic adv();
        for (int i = 0; i < 3; i++) begin
            bit st = m_stall(i);
            bit fl = m_flush();
            bit enter = id_valid && !st && !fl;
            int mx = (1 << p_cw[i]) - 1;
            if (!rst_n) begin
                for (int a = 0; a < 3; a++) hist[i][a] = '{0, 0, 0, 0};
                e_fa[i] = 0; e_fb[i] = 0; e_sc[i] = 0; e_fc[i] = 0;
            end else begin
                e_fa[i] = enter ? m_src(i, id_rs1_used, int'(id_rs1)) : 0;
                e_fb[i] = enter ? m_src(i, id_rs2_used, int'(id_rs2)) : 0;
                if (st && e_sc[i] < mx) e_sc[i]++;
                if (fl && e_fc[i] < mx) e_fc[i]++;
                hist[i][2] = hist[i][1];
                hist[i][1] = hist[i][0];
                hist[i][0] = '{enter, id_wr_en, id_is_load, int'(id_rd)};
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic d_nop();                          drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic d_wr(input int rd, input bit ld); drive(1, 1, 0, 0, 0, 0, 1, rd, ld, 0); endtask
    task automatic d_use(input int r1, input bit a, input int r2, input bit b, input bit redir);
        drive(1, 1, r1, a, r2, b, 0, 0, 0, redir);
    endtask
    task automatic do_reset();
        drive(0, 1, 3, 1, 3, 1, 1, 3, 1, 1);
        adv();
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0;
        id_rs2_used = 1'b0; id_wr_en = 1'b0; id_rd = '0; id_is_load = 1'b0; ex_redirect = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state; stall/flush forced low even with redirect and a would-be hazard.
        drive(0, 1, 3, 1, 3, 1, 1, 3, 1, 1);
        chk("rst.u0.flush", {31'b0, fl0}, 0);
        chk("rst.u0.stall_cnt", {16'b0, sc0}, 0);
        adv();

        // Load-use with forwarding: one stall cycle, then WB forward.
        do_reset();
        d_wr(3, 1); adv();
        d_use(3, 1, 0, 0, 0); chk("lu.u0.stall1", {31'b0, st0}, 1); adv();
        d_use(3, 1, 0, 0, 0); chk("lu.u0.stall2", {31'b0, st0}, 0); adv();
        d_nop(); chk("lu.u0.fwd_a", {30'b0, fa0}, 2); chk("lu.u0.stall_cnt", {16'b0, sc0}, 1); adv();

        // ALU producer: back-to-back -> MEM forward, one gap -> WB forward, youngest wins.
        do_reset();
        d_wr(5, 0); adv();
        d_use(0, 0, 5, 1, 0); chk("alu.u0.stall", {31'b0, st0}, 0); adv();
        d_nop(); chk("alu.u0.fwd_b01", {30'b0, fb0}, 1); adv();
        d_wr(5, 0); adv();
        d_wr(7, 0); adv();
        d_use(0, 0, 5, 1, 0); adv();
        d_nop(); chk("alu.u0.fwd_b10", {30'b0, fb0}, 2); adv();
        d_wr(6, 0); adv();
        d_wr(6, 0); adv();
        d_use(6, 1, 0, 0, 0); adv();
        d_nop(); chk("young.u0.fwd_a", {30'b0, fa0}, 1); adv();

        // No forwarding: two stall cycles on an immediate consumer.
        do_reset();
        d_wr(2, 0); adv();
        d_use(2, 1, 0, 0, 0); chk("nf.u1.stall1", {31'b0, st1}, 1); adv();
        d_use(2, 1, 0, 0, 0); chk("nf.u1.stall2", {31'b0, st1}, 1); adv();
        d_use(2, 1, 0, 0, 0); chk("nf.u1.stall3", {31'b0, st1}, 0);
        chk("nf.u1.stall_cnt", {30'b0, sc1}, 2); adv();
        d_nop(); chk("nf.u1.fwd_a", {30'b0, fa1}, 0); adv();

        // Redirect overrides a load-use hazard and bubbles EX.
        do_reset();
        d_wr(4, 1); adv();
        d_use(4, 1, 0, 0, 1);
        chk("rd.u0.flush", {31'b0, fl0}, 1); chk("rd.u0.stall", {31'b0, st0}, 0); adv();
        d_use(4, 1, 0, 0, 0);
        chk("rd.u0.stall_after", {31'b0, st0}, 0);
        chk("rd.u0.flush_cnt", {16'b0, fc0}, 1); chk("rd.u0.stall_cnt", {16'b0, sc0}, 0); adv();

        // Hard-wired r0 never creates a hazard or a forward.
        do_reset();
        d_wr(0, 1); adv();
        d_use(0, 1, 0, 1, 0);
        chk("zr.u2.stall", {31'b0, st2}, 0); chk("zr.u0.stall", {31'b0, st0}, 1); adv();
        d_nop(); chk("zr.u2.fwd_a", {30'b0, fa2}, 0); chk("zr.u2.fwd_b", {30'b0, fb2}, 0); adv();

        // Reset for one edge in the middle of a stall.
        do_reset();
        d_wr(3, 1); adv();
        d_use(3, 1, 0, 0, 0); chk("mr.u0.stall_pre", {31'b0, st0}, 1); adv();
        drive(0, 1, 3, 1, 0, 0, 0, 0, 0, 0); chk("mr.u0.stall_rst", {31'b0, st0}, 0); adv();
        d_use(3, 1, 0, 0, 0);
        chk("mr.u0.stall_post", {31'b0, st0}, 0); chk("mr.u0.stall_cnt", {16'b0, sc0}, 0); adv();

        // Counter saturation on the 2-bit instance: six stall cycles.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            d_wr(1, 0); adv();
            d_use(1, 1, 0, 0, 0); adv();
            d_use(1, 1, 0, 0, 0); adv();
            d_use(1, 1, 0, 0, 0); adv();
            if (k == 0) begin
                d_nop(); chk("sat.u1.cnt2", {30'b0, sc1}, 2); adv();
            end
        end
        d_nop(); chk("sat.u1.cnt3", {30'b0, sc1}, 3); adv();

        // Randomized traffic over a small register range to provoke hazards.
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
